gpmc_bus_master: RTL and testbench
==================================

Name: gpmc_bus_master

Overview:
- Upstream stage of the chip-select bus decoder.
- Converts the BeagleBone GPMC asynchronous multiplexed address/data interface into single-clock bus transactions.
- Issues an address plus an active-low bus strobe. The decoder turns these into per-device chip selects.
- Waits for the addressed device's acknowledge, then returns read data to the GPMC.

Parameters:
- ADDR_WIDTH, 16, total bus address width (device address bits + bus select bits).
- DATA_WIDTH, 16, GPMC data width.
- SYNC_STAGES, 2, synchronizer depth on all GPMC inputs (min 2).
- TIMEOUT_CYCLES, 255, clk cycles to wait for bus_ack before abort (used only with GPMC_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- gpmc_csn  input  1  GPMC chip select, active low
- gpmc_advn  input  1  address valid, active low
- gpmc_wen  input  1  write enable, active low
- gpmc_oen  input  1  output enable, active low
- gpmc_ad_in  input  DATA_WIDTH  AD bus, input side
- gpmc_ad_out  output  DATA_WIDTH  AD bus, output side
- gpmc_ad_oe  output  1  AD tristate enable (1 = FPGA drives)
- bus_addr  output  ADDR_WIDTH  transaction address to decoder
- bus_cs  output  1  bus strobe, active low
- bus_we  output  1  1 = write, 0 = read
- bus_wdata  output  DATA_WIDTH  write data
- bus_rdata  input  DATA_WIDTH  read data from selected device
- bus_ack  input  1  device done, single-cycle pulse
- bus_err  output  1  sticky timeout flag (tied 0 without GPMC_TIMEOUT_EN)

Behaviour:
- Reset values:
  - gpmc_ad_out=0, gpmc_ad_oe=0
  - bus_addr=0, bus_cs=1, bus_we=0, bus_wdata=0, bus_err=0
  - all synchronizer flops: csn/advn/wen/oen=1, ad=0
  - state=IDLE
- Synchronization:
  - Every gpmc_* input passes through SYNC_STAGES flops.
  - Edge detection compares the last two synchronized samples.
  - gpmc_ad_in is synchronized at the same depth, so it stays aligned with the strobes.
- State machine:
  - IDLE: on synced csn=0 and an advn rising edge, latch bus_addr from synced AD (upper bits zero-filled if ADDR_WIDTH>DATA_WIDTH) -> CMD.
  - CMD:
    - wen rising edge: latch bus_wdata from synced AD, bus_we=1 -> REQ.
    - oen falling edge: bus_we=0 -> REQ.
    - csn returns high: -> IDLE with no bus activity.
  - REQ: bus_cs=0, held until bus_ack is sampled 1.
    - Write: bus_cs=1 -> DONE.
    - Read: capture bus_rdata into gpmc_ad_out, gpmc_ad_oe=1 -> DRIVE.
  - DRIVE: hold gpmc_ad_oe=1 until synced oen rises or csn rises, then gpmc_ad_oe=0 -> DONE.
  - DONE: wait for synced csn=1 -> IDLE.
- Latency:
  - bus_cs falls 1 clk after the triggering synced edge is detected.
  - bus_cs rises in the cycle after bus_ack is sampled.
  - Read data reaches gpmc_ad_out 1 clk after bus_ack.
- bus_ack arriving in the same cycle bus_cs asserts is not possible, because devices see bus_cs registered; ack is accepted only in REQ.
- bus_ack in any other state is ignored.
- Abort conditions:
  - csn rises while in REQ: transaction continues until ack (no orphaned device access); the result is discarded, then -> IDLE.
  - advn falling while not in IDLE: ignored.
  - Back-to-back transactions: a new address phase is recognised only from IDLE, so the previous one must reach DONE and see csn high.
- gpmc_ad_oe is never 1 outside DRIVE; it is guaranteed 0 while synced wen=0.
- Reset is asynchronous and active-high; asserting it mid-transaction forces all outputs to their reset values immediately, including releasing the AD bus.

Optional Feature:
- Macro: GPMC_TIMEOUT_EN
- Defined:
  - An 8+ bit counter runs in REQ.
  - If TIMEOUT_CYCLES elapse without bus_ack: bus_cs=1, bus_err=1 (sticky until reset).
  - Reads return 16'hDEAD (truncated/extended to DATA_WIDTH) and proceed to DRIVE.
  - Writes proceed to DONE.
- Not defined:
  - No counter; REQ waits indefinitely for bus_ack.
  - bus_err is constant 0.

Test Plan:
- Write 0x1234 to address 0x4002 with ack 3 clk after bus_cs falls:
  - bus_addr=0x4002, bus_we=1, bus_wdata=0x1234.
  - bus_cs low exactly until the cycle after ack.
  - gpmc_ad_oe stays 0 throughout.
- Read address 0xC010 with device returning bus_rdata=0xBEEF:
  - bus_we=0.
  - gpmc_ad_out=0xBEEF with gpmc_ad_oe=1 from 1 clk after ack until oen rises, then 0.
- csn toggles low/high with advn pulse but no wen/oen:
  - bus_cs never asserts; FSM back in IDLE.
- Reset asserted during DRIVE:
  - gpmc_ad_oe drops to 0 asynchronously.
  - bus_cs=1.
  - Next transaction behaves normally.
- GPMC_TIMEOUT_EN, TIMEOUT_CYCLES=8, read with no ack:
  - bus_cs released after 8 clk.
  - bus_err=1.
  - gpmc_ad_out=0xDEAD.
- Spurious bus_ack pulses in IDLE and CMD:
  - No state change.
  - Subsequent write completes correctly.

Source files
------------

// File: rtl/gpmc_bus_master.sv
// gpmc_bus_master: bridges the GPMC async muxed AD interface to single-clock strobe/ack bus transactions.
// Define GPMC_TIMEOUT_EN to add a bus_ack watchdog with a sticky bus_err flag.
module gpmc_bus_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gpmc_csn,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_wen,
  input  logic                  gpmc_oen,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_cs,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err
);
  typedef enum logic [2:0] {IDLE, CMD, REQ, DRIVE, DONE} state_t;
  state_t state, next;
  logic [SYNC_STAGES-1:0] csn_q, advn_q, wen_q, oen_q;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] ad_q;
  logic advn_p, wen_p, oen_p, oe_q, abort, tmo, done;
  logic csn_s, advn_s, wen_s, oen_s, advn_rise, wen_rise, oen_fall;
  logic [DATA_WIDTH-1:0] ad_s, rd_val;
  assign csn_s     = csn_q[SYNC_STAGES-1];
  assign advn_s    = advn_q[SYNC_STAGES-1];
  assign wen_s     = wen_q[SYNC_STAGES-1];
  assign oen_s     = oen_q[SYNC_STAGES-1];
  assign ad_s      = ad_q[SYNC_STAGES-1];
  assign advn_rise = advn_s && !advn_p;
  assign wen_rise  = wen_s && !wen_p;
  assign oen_fall  = !oen_s && oen_p;
  assign done      = bus_ack || tmo;
  // AD shares the strobes' depth so the latched value lines up with the detected edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      csn_q  <= '1;
      advn_q <= '1;
      wen_q  <= '1;
      oen_q  <= '1;
      ad_q   <= '0;
      advn_p <= 1'b1;
      wen_p  <= 1'b1;
      oen_p  <= 1'b1;
    end else begin
      csn_q  <= {csn_q[SYNC_STAGES-2:0], gpmc_csn};
      advn_q <= {advn_q[SYNC_STAGES-2:0], gpmc_advn};
      wen_q  <= {wen_q[SYNC_STAGES-2:0], gpmc_wen};
      oen_q  <= {oen_q[SYNC_STAGES-2:0], gpmc_oen};
      ad_q   <= {ad_q[SYNC_STAGES-2:0], gpmc_ad_in};
      advn_p <= advn_s;
      wen_p  <= wen_s;
      oen_p  <= oen_s;
    end
`ifdef GPMC_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  assign tmo    = state == REQ && !bus_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign rd_val = bus_ack ? bus_rdata : DATA_WIDTH'(16'hDEAD);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt     <= state == REQ ? cnt + CW'(1) : '0;
      bus_err <= bus_err || tmo;
    end
`else
  assign tmo     = 1'b0;
  assign rd_val  = bus_rdata;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !csn_s && advn_rise ? CMD : IDLE;
      CMD:     next = wen_rise || oen_fall ? REQ : csn_s ? IDLE : CMD;
      REQ:     next = !done ? REQ : abort || csn_s ? IDLE : bus_we ? DONE : DRIVE;
      DRIVE:   next = oen_s || csn_s || !wen_s ? DONE : DRIVE;
      DONE:    next = csn_s ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  // a started device access always runs to ack; a csn release during it only discards the result
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus_addr    <= '0;
      bus_cs      <= 1'b1;
      bus_we      <= 1'b0;
      bus_wdata   <= '0;
      gpmc_ad_out <= '0;
      oe_q        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      bus_cs <= next != REQ;
      oe_q   <= next == DRIVE;
      abort  <= state == REQ && (abort || csn_s);
      if (state == IDLE && next == CMD) bus_addr <= ADDR_WIDTH'(ad_s);
      if (state == CMD && wen_rise) begin
        bus_we    <= 1'b1;
        bus_wdata <= ad_s;
      end else if (state == CMD && oen_fall) bus_we <= 1'b0;
      if (state == REQ && next == DRIVE) gpmc_ad_out <= rd_val;
    end
  assign gpmc_ad_oe = oe_q && wen_s;
endmodule

// File: tb/tb_gpmc_bus_master.sv
// tb_gpmc_bus_master: directed write/read/abort/reset/spurious-ack vectors against gpmc_bus_master.
module tb_gpmc_bus_master;
  logic clk = 0, reset = 1, gpmc_csn = 1, gpmc_advn = 1, gpmc_wen = 1, gpmc_oen = 1, bus_ack = 0;
  logic [15:0] gpmc_ad_in = 0, bus_rdata = 0;
  logic [15:0] gpmc_ad_out, bus_addr, bus_wdata;
  logic gpmc_ad_oe, bus_cs, bus_we, bus_err;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gpmc_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .gpmc_csn(gpmc_csn), .gpmc_advn(gpmc_advn), .gpmc_wen(gpmc_wen),
    .gpmc_oen(gpmc_oen), .gpmc_ad_in(gpmc_ad_in), .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe),
    .bus_addr(bus_addr), .bus_cs(bus_cs), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic addr_phase(input logic [15:0] a);
    @(negedge clk);
    gpmc_csn = 0;
    gpmc_advn = 0;
    gpmc_ad_in = a;
    tick(2);
    gpmc_advn = 1;
    tick(4);
  endtask
  task automatic wait_cs(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++)
      if (!bus_cs) ok = 1;
      else tick(1);
    check(tag, ok, 1);
  endtask
  task automatic end_txn();
    gpmc_csn = 1;
    gpmc_oen = 1;
    gpmc_wen = 1;
    tick(4);
  endtask
  task automatic write_data(input logic [15:0] a, input logic [15:0] d, input string tag);
    gpmc_ad_in = d;
    gpmc_wen = 0;
    tick(2);
    check({tag, "_oe_wen"}, gpmc_ad_oe, 0);
    gpmc_wen = 1;
    wait_cs({tag, "_cs_fall"});
    check({tag, "_addr"}, bus_addr, a);
    check({tag, "_we"}, bus_we, 1);
    check({tag, "_wdata"}, bus_wdata, d);
    tick(2);
    check({tag, "_cs_held"}, bus_cs, 0);
    bus_ack = 1;
    tick(1);
    bus_ack = 0;
    check({tag, "_cs_rise"}, bus_cs, 1);
    check({tag, "_oe"}, gpmc_ad_oe, 0);
    end_txn();
  endtask
  task automatic read_to_drive(input logic [15:0] a, input logic [15:0] d, input string tag);
    addr_phase(a);
    gpmc_oen = 0;
    bus_rdata = d;
    wait_cs({tag, "_cs_fall"});
    check({tag, "_addr"}, bus_addr, a);
    check({tag, "_we"}, bus_we, 0);
    check({tag, "_oe_req"}, gpmc_ad_oe, 0);
    tick(2);
    bus_ack = 1;
    tick(1);
    bus_ack = 0;
    check({tag, "_rdata"}, gpmc_ad_out, d);
    check({tag, "_oe"}, gpmc_ad_oe, 1);
    check({tag, "_cs_rise"}, bus_cs, 1);
  endtask
  initial begin
    bit low_seen;
    int n;
    tick(2);
    check("rst_cs", bus_cs, 1);
    check("rst_oe", gpmc_ad_oe, 0);
    check("rst_ad_out", gpmc_ad_out, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_we", bus_we, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_err", bus_err, 0);
    reset = 0;
    tick(2);
    bus_ack = 1;
    tick(1);
    bus_ack = 0;
    tick(2);
    check("idle_ack_cs", bus_cs, 1);
    addr_phase(16'h4002);
    write_data(16'h4002, 16'h1234, "wr1");
    read_to_drive(16'hC010, 16'hBEEF, "rd1");
    gpmc_oen = 1;
    tick(1);
    check("rd1_oe_hold", gpmc_ad_oe, 1);
    tick(3);
    check("rd1_oe_off", gpmc_ad_oe, 0);
    end_txn();
    addr_phase(16'h1111);
    check("nop_addr", bus_addr, 16'h1111);
    gpmc_csn = 1;
    low_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (!bus_cs) low_seen = 1;
    end
    check("nop_cs", low_seen, 0);
    addr_phase(16'h2002);
    bus_ack = 1;
    tick(1);
    bus_ack = 0;
    tick(1);
    check("cmd_ack_cs", bus_cs, 1);
    write_data(16'h2002, 16'h5678, "wr2");
    read_to_drive(16'h8080, 16'h5A5A, "rd2");
    #2 reset = 1;
    #1;
    check("arst_oe", gpmc_ad_oe, 0);
    check("arst_cs", bus_cs, 1);
    check("arst_ad_out", gpmc_ad_out, 0);
    check("arst_addr", bus_addr, 0);
    tick(1);
    reset = 0;
    end_txn();
    addr_phase(16'h0F0F);
    write_data(16'h0F0F, 16'hA5A5, "wr3");
`ifdef GPMC_TIMEOUT_EN
    addr_phase(16'h3000);
    gpmc_oen = 0;
    wait_cs("to_cs_fall");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_cs) n++;
      tick(1);
    end
    check("to_cs_len", n, 8);
    check("to_err", bus_err, 1);
    check("to_dead", gpmc_ad_out, 16'hDEAD);
    check("to_oe", gpmc_ad_oe, 1);
    end_txn();
    check("to_oe_off", gpmc_ad_oe, 0);
`else
    n = 0;
    check("err_tied", bus_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
